// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and EX flush.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_COUNT_EN.
module id_ex_stage_register #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_flush,
  input  logic              mem_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm_ext,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              hazard_stall
`ifdef ID_EX_BUBBLE_COUNT_EN
  ,
  output logic [CNT_W-1:0]  bubble_count
`endif
);

  logic rs_match;
  logic rt_match;
  logic insert_bubble;

  // A load in EX whose destination is read by the ID instruction; r0 never conflicts.
  assign rs_match      = id_uses_rs && (id_rs == ex_rt);
  assign rt_match      = id_uses_rt && (id_rt == ex_rt);
  assign hazard_stall  = ex_valid && ex_mem_read && (ex_rt != '0) && id_valid && (rs_match || rt_match);
  assign insert_bubble = ex_flush || hazard_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc_plus4  <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm_ext   <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_ctrl      <= '0;
    end else if (!mem_stall) begin
      if (insert_bubble) begin
        // Data and index fields keep their old values; only side-effecting bits clear.
        ex_valid     <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_ctrl      <= '0;
      end else begin
        ex_valid     <= id_valid;
        ex_pc_plus4  <= id_pc_plus4;
        ex_rs_data   <= id_rs_data;
        ex_rt_data   <= id_rt_data;
        ex_imm_ext   <= id_imm_ext;
        ex_rs        <= id_rs;
        ex_rt        <= id_rt;
        ex_rd        <= id_rd;
        ex_mem_read  <= id_valid && id_mem_read;
        ex_reg_write <= id_valid && id_reg_write;
        ex_ctrl      <= id_valid ? id_ctrl : '0;
      end
    end
  end

`ifdef ID_EX_BUBBLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (!mem_stall && insert_bubble && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end
`endif

endmodule
